// File: rtl/tdm_demux_8to1.sv
// tdm_demux_8to1: TDM serial-to-parallel demultiplexer.
// Rebuilds an 8-bit word from a one-bit-per-slot serial stream. Sel is the
// slot expected for the next accepted bit, so it tracks the far-end mux select.
// Optional build macro TDM_DEMUX_PARITY_EN adds a 9th (even parity) slot and
// the par_err output.
module tdm_demux_8to1 #(
  parameter int WIDTH         = 8,
  parameter int FRAME_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             F,
  input  logic             valid_in,
  input  logic             sync,
  output logic [2:0]       Sel,
  output logic [WIDTH-1:0] Y,
  output logic             Y_valid,
  output logic             busy,
  output logic             frame_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [2:0]    LAST_SLOT = 3'(WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(FRAME_TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_buf;
  logic [WIDTH-1:0] r_y;
  logic             r_y_valid;
  logic             r_busy;
  logic             r_frame_err;
  logic [TW-1:0]    r_tcnt;
  logic             w_mid_frame;
`ifdef TDM_DEMUX_PARITY_EN
  logic             r_par_slot;
  logic             r_par_err;
`endif

  // A frame is partially received when past slot 0 or waiting for parity.
  always_comb begin
    w_mid_frame = (r_sel != 3'd0);
`ifdef TDM_DEMUX_PARITY_EN
    w_mid_frame = w_mid_frame | r_par_slot;
`endif
  end

  // Slot tracking FSM: frame assembly, sync restart and idle timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_buf       <= '0;
      r_y         <= '0;
      r_y_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_tcnt      <= '0;
`ifdef TDM_DEMUX_PARITY_EN
      r_par_slot  <= 1'b0;
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_y_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tcnt <= '0;
          if (valid_in && sync) begin
            r_buf   <= {{(WIDTH-1){1'b0}}, F};
            r_sel   <= 3'd1;
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (valid_in) begin
            r_tcnt <= '0;
            if (sync) begin
              // Sync always wins, even on the last slot: restart at slot 0.
              if (w_mid_frame)
                r_frame_err <= 1'b1;
              r_buf <= {{(WIDTH-1){1'b0}}, F};
              r_sel <= 3'd1;
`ifdef TDM_DEMUX_PARITY_EN
              r_par_slot <= 1'b0;
            end else if (r_par_slot) begin
              r_y        <= r_buf;
              r_par_err  <= ^{r_buf, F};
              r_y_valid  <= 1'b1;
              r_sel      <= '0;
              r_par_slot <= 1'b0;
            end else if (r_sel == LAST_SLOT) begin
              // Sel holds at 7 through the parity slot.
              r_buf[LAST_SLOT] <= F;
              r_par_slot       <= 1'b1;
`else
            end else if (r_sel == LAST_SLOT) begin
              r_y       <= {F, r_buf[WIDTH-2:0]};
              r_y_valid <= 1'b1;
              r_sel     <= '0;
`endif
            end else begin
              r_buf[r_sel] <= F;
              r_sel        <= r_sel + 3'd1;
            end
          end else if (r_tcnt == TO_LAST) begin
            if (w_mid_frame)
              r_frame_err <= 1'b1;
            r_tcnt  <= '0;
            r_sel   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            r_par_slot <= 1'b0;
`endif
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Sel       = r_sel;
  assign Y         = r_y;
  assign Y_valid   = r_y_valid;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err   = r_par_err;
`endif

endmodule

// File: tb/tb_tdm_demux_8to1.sv
// Testbench for tdm_demux_8to1: directed scenarios plus random traffic,
// every cycle compared against a frame-level reference model.
module tb_tdm_demux_8to1;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int NS = 9;
`else
  localparam int NS = 8;
`endif
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n, F, valid_in, sync;
  logic [2:0] Sel;
  logic [7:0] Y;
  logic       Y_valid, busy, frame_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic       par_err;
`endif

  tdm_demux_8to1 #(.WIDTH(8), .FRAME_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .F(F), .valid_in(valid_in), .sync(sync),
    .Sel(Sel), .Y(Y), .Y_valid(Y_valid), .busy(busy), .frame_err(frame_err)
`ifdef TDM_DEMUX_PARITY_EN
    , .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: list of bits collected for the current frame.
  bit         m_run;
  int         m_pos;
  int         m_idle;
  bit         m_bits[NS];
  logic [7:0] m_y;
  bit         m_yv, m_fe, m_pe;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_idle = 0;
    m_y = '0; m_yv = 0; m_fe = 0; m_pe = 0;
  endtask

  task automatic model_clock(input bit v, input bit s, input bit f);
    int w;
    bit p;
    m_yv = 0;
    m_fe = 0;
    if (!m_run) begin
      if (v && s) begin
        m_bits[0] = f; m_pos = 1; m_run = 1; m_idle = 0;
      end
    end else if (v) begin
      m_idle = 0;
      if (s) begin
        if (m_pos != 0) m_fe = 1;
        m_bits[0] = f;
        m_pos = 1;
      end else begin
        m_bits[m_pos] = f;
        m_pos++;
        if (m_pos == NS) begin
          w = 0;
          p = 0;
          for (int i = 0; i < 8; i++) w += int'(m_bits[i]) * (1 << i);
          for (int i = 0; i < NS; i++) p ^= m_bits[i];
          m_y = 8'(w);
          m_pe = p;
          m_yv = 1;
          m_pos = 0;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        if (m_pos != 0) m_fe = 1;
        m_run = 0; m_pos = 0; m_idle = 0;
      end
    end
  endtask

  task automatic check_all();
    check_eq("Sel", 32'(Sel), (m_pos > 7) ? 32'd7 : 32'(m_pos));
    check_eq("Y", 32'(Y), 32'(m_y));
    check_eq("Y_valid", 32'(Y_valid), 32'(m_yv));
    check_eq("busy", 32'(busy), 32'(m_run));
    check_eq("frame_err", 32'(frame_err), 32'(m_fe));
`ifdef TDM_DEMUX_PARITY_EN
    if (m_yv) check_eq("par_err", 32'(par_err), 32'(m_pe));
`endif
  endtask

  task automatic step(input bit v, input bit s, input bit f);
    @(negedge clk);
    valid_in = v; sync = s; F = f;
    @(posedge clk);
    if (rst_n) model_clock(v, s, f);
    else model_reset();
    #1 check_all();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit with_sync);
    for (int i = 0; i < 8; i++) step(1'b1, with_sync && (i == 0), d[i]);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, ^d);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic async_reset();
    @(negedge clk);
    valid_in = 1'b0; sync = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; sync = 1'b0; F = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // First frame 0x01 with sync on slot 0.
    send_frame(8'h01, 1'b1);
    idle(2);

    // Walking one, back-to-back frames after the first sync.
    for (int k = 0; k < 8; k++) send_frame(8'(1 << k), k == 0);
    idle(2);

    // Stall between slots 3 and 4.
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'(8'hA5 >> i));
    idle(3);
    for (int i = 4; i < 8; i++) step(1'b1, 1'b0, 1'(8'hA5 >> i));
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, ^8'hA5);
`endif
    idle(2);

    // Sync at Sel=5, then a full 0xFF frame.
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b0);
    send_frame(8'hFF, 1'b1);
    idle(2);

    // Sync on the last data slot.
    for (int i = 0; i < 8; i++) step(1'b1, (i == 0) || (i == 7), 1'b1);
    idle(1);

    // Timeout mid-frame at Sel=3, then bits without sync are ignored.
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, 1'b1);
    idle(TO);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));

    // Timeout at Sel=0 after a complete frame leaves silently.
    send_frame(8'h3C, 1'b1);
    idle(TO + 2);

    // Asynchronous reset mid-frame.
    send_frame(8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1);
    async_reset();
    idle(2);

`ifdef TDM_DEMUX_PARITY_EN
    // Data 0x03 with parity bit 1 flags a parity error.
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, 1'(8'h03 >> i));
    step(1'b1, 1'b0, 1'b1);
    idle(2);
`endif

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) idle(TO + 1);
      else if ($urandom_range(0, 499) == 0) async_reset();
      else step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 4,
                1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
